sram_obi_arbiter: RTL and testbench

- Shares one single-port inferred SRAM macro (req/we/addr/wdata/be in, rdata out, fixed read latency) between NUM_PORTS OBI-style requesters, for example the core's instruction-fetch and data ports on the FPGA target.
- Arbitration is round-robin. Grant is combinational, in the same cycle as the request.
- The block converts byte addresses to word indices and forwards the request to the SRAM.
- It tracks in-flight accesses so that each rvalid/rdata is returned to the port that issued it.

---
 rtl/sram_arb_pkg.sv | 21 ++
 rtl/sram_obi_arbiter_rr_arbiter.sv | 44 ++++
 rtl/sram_obi_arbiter.sv | 106 ++++++++++
 tb/tb_sram_obi_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM OBI arbiter: port index, response-pipeline stage
// and the round-robin pointer helper.
package sram_arb_pkg;

    localparam int MAX_PORTS   = 4;
    localparam int MAX_LATENCY = 2;
    localparam int IDX_W       = (MAX_PORTS > 1) ? $clog2(MAX_PORTS) : 1;

    // Sized for the largest supported port count so one type serves every build.
    typedef logic [IDX_W-1:0] port_idx_t;

    typedef struct packed {
        logic      valid;
        port_idx_t idx;
    } rsp_stage_t;

    function automatic port_idx_t next_ptr(input port_idx_t cur, input int num_ports);
        return (int'(cur) >= num_ports - 1) ? '0 : cur + port_idx_t'(1);
    endfunction

endpackage

// File: rtl/sram_obi_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// the pointer, wrapping around to port 0.
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  port_idx_t            ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output port_idx_t            idx,
    output logic                 any
);

    logic [NUM_PORTS-1:0] upper;
    logic [NUM_PORTS-1:0] masked;
    port_idx_t            idx_masked;
    port_idx_t            idx_all;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign upper[gi] = (port_idx_t'(gi) >= ptr);
            assign gnt[gi]   = any && (idx == port_idx_t'(gi));
        end
    endgenerate

    assign masked = req & upper;
    assign any    = |req;

    // Lowest set bit wins; the masked search handles ports at or after ptr,
    // the unmasked one provides the wrap-around.
    always_comb begin
        idx_masked = '0;
        idx_all    = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (masked[i]) idx_masked = port_idx_t'(i);
            if (req[i])    idx_all    = port_idx_t'(i);
        end
    end

    assign idx = (|masked) ? idx_masked : idx_all;

endmodule

// File: rtl/sram_obi_arbiter.sv
// Shares one single-port SRAM between NUM_PORTS OBI requesters with a
// same-cycle round-robin grant and a latency-matched response pipeline.
module sram_obi_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_PORTS    = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_WORDS    = 16384,
    parameter int ADDR_WIDTH   = 32,
    parameter int SRAM_LATENCY = 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NUM_PORTS-1:0]                    req_i,
    output logic [NUM_PORTS-1:0]                    gnt_o,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]    addr_i,
    input  logic [NUM_PORTS-1:0]                    we_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]  be_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    wdata_i,
    output logic [NUM_PORTS-1:0]                    rvalid_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    rdata_o,
    output logic                                    sram_req_o,
    output logic                                    sram_we_o,
    output logic [$clog2(NUM_WORDS)-1:0]            sram_addr_o,
    output logic [DATA_WIDTH-1:0]                   sram_wdata_o,
    output logic [DATA_WIDTH/8-1:0]                 sram_be_o,
    input  logic [DATA_WIDTH-1:0]                   sram_rdata_i
);

    localparam int WORD_AW = $clog2(NUM_WORDS);
    localparam int OFF_W   = $clog2(DATA_WIDTH / 8);

    logic [NUM_PORTS-1:0] req_eff;
    logic [NUM_PORTS-1:0] gnt;
    logic                 any;
    port_idx_t            win_idx;
    port_idx_t            ptr_reg;
    port_idx_t            ptr_next;
    rsp_stage_t           pipe_reg [SRAM_LATENCY];
    rsp_stage_t           last_stage;
    logic                 unused_addr;

    // Requests are masked while reset is held so nothing is granted or forwarded.
    assign req_eff = rst_ni ? req_i : '0;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_arbiter (
        .req (req_eff),
        .ptr (ptr_reg),
        .gnt (gnt),
        .idx (win_idx),
        .any (any)
    );

    assign gnt_o    = gnt;
    assign ptr_next = any ? next_ptr(win_idx, NUM_PORTS) : ptr_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_reg <= '0;
        else         ptr_reg <= ptr_next;
    end

    // AND-OR mux on the one-hot grant; every SRAM field falls to 0 when idle.
    always_comb begin
        sram_we_o    = 1'b0;
        sram_be_o    = '0;
        sram_wdata_o = '0;
        sram_addr_o  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt[i]) begin
                sram_we_o    = we_i[i];
                sram_be_o    = be_i[i];
                sram_wdata_o = wdata_i[i];
                sram_addr_o  = addr_i[i][OFF_W +: WORD_AW];
            end
        end
    end

    assign sram_req_o  = any;
    assign unused_addr = ^addr_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SRAM_LATENCY; s++) pipe_reg[s] <= '0;
        end else begin
            pipe_reg[0] <= rsp_stage_t'{valid: any, idx: win_idx};
            for (int s = 1; s < SRAM_LATENCY; s++) pipe_reg[s] <= pipe_reg[s-1];
        end
    end

    assign last_stage = pipe_reg[SRAM_LATENCY-1];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rsp
            assign rvalid_o[gi] = last_stage.valid && (last_stage.idx == port_idx_t'(gi));
            assign rdata_o[gi]  = sram_rdata_i;
        end
    endgenerate

    a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
    a_gnt_subset : assert property (@(posedge clk_i) disable iff (!rst_ni) (gnt_o & ~req_i) == '0);
    a_rvalid_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rvalid_o));

endmodule

// File: tb/tb_sram_obi_arbiter.sv
// Directed bench for sram_obi_arbiter: one latency-1 and one latency-2 instance
// share the stimulus; a scoreboard queue feeds a response monitor per instance.
module tb_sram_obi_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    logic [1:0]       req = '0;
    logic [1:0]       we = '0;
    logic [1:0][31:0] addr = '0;
    logic [1:0][31:0] wdata = '0;
    logic [1:0][3:0]  be = '0;

    logic [1:0]       gnt1, gnt2, rv1, rv2;
    logic [1:0][31:0] rdata1, rdata2;
    logic             s1_req, s1_we, s2_req, s2_we;
    logic [9:0]       s1_addr, s2_addr;
    logic [31:0]      s1_wd, s2_wd, s1_rd, s2_rd, r2a;
    logic [3:0]       s1_be, s2_be;

    logic [31:0] mem1 [1024];
    logic [31:0] mem2 [1024];

    typedef struct {
        logic [1:0]  port;
        int          issue;
        bit          chk;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int fails = 0;
    int ix1 = 0;
    int ix2 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_obi_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(32), .NUM_WORDS(1024),
                       .ADDR_WIDTH(32), .SRAM_LATENCY(1)) dut_l1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt1), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rv1), .rdata_o(rdata1),
        .sram_req_o(s1_req), .sram_we_o(s1_we), .sram_addr_o(s1_addr),
        .sram_wdata_o(s1_wd), .sram_be_o(s1_be), .sram_rdata_i(s1_rd));

    sram_obi_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(32), .NUM_WORDS(1024),
                       .ADDR_WIDTH(32), .SRAM_LATENCY(2)) dut_l2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt2), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rv2), .rdata_o(rdata2),
        .sram_req_o(s2_req), .sram_we_o(s2_we), .sram_addr_o(s2_addr),
        .sram_wdata_o(s2_wd), .sram_be_o(s2_be), .sram_rdata_i(s2_rd));

    // Behavioural SRAM macros: one and two cycles of read latency.
    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem1[i] = '0;
            mem2[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (s1_req) begin
            if (s1_we) begin
                for (int b = 0; b < 4; b++)
                    if (s1_be[b]) mem1[s1_addr][b*8 +: 8] <= s1_wd[b*8 +: 8];
            end else begin
                s1_rd <= mem1[s1_addr];
            end
        end
    end

    always @(posedge clk) begin
        if (s2_req) begin
            if (s2_we) begin
                for (int b = 0; b < 4; b++)
                    if (s2_be[b]) mem2[s2_addr][b*8 +: 8] <= s2_wd[b*8 +: 8];
            end else begin
                r2a <= mem2[s2_addr];
            end
        end
        s2_rd <= r2a;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic mon_step(input string nm, input int lat, input logic [1:0] rv,
                            input logic [1:0][31:0] rd, inout int ix);
        exp_t e;
        logic [31:0] d;
        if (ix < exp_q.size() && exp_q[ix].issue + lat <= cyc) begin
            e = exp_q[ix];
            ix++;
            checks++;
            d = e.port[1] ? rd[1] : rd[0];
            if (rv !== e.port || (e.chk && d !== e.data)) begin
                fails++;
                $display("FAIL %s at cycle %0d: rvalid %b rdata %h, expected rvalid %b rdata %h",
                         nm, cyc, rv, d, e.port, e.data);
            end
        end else if (rv !== 2'b00) begin
            checks++;
            fails++;
            $display("FAIL %s at cycle %0d: unexpected rvalid %b, expected 00", nm, cyc, rv);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            mon_step("rsp_lat1", 1, rv1, rdata1, ix1);
            mon_step("rsp_lat2", 2, rv2, rdata2, ix2);
        end
    end

    // One arbitration cycle: drive, check the combinational grant and SRAM
    // address, and record the expected response.
    task automatic step(input logic [1:0] r, input logic [1:0] w,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [3:0] b0, input logic [3:0] b1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] eg, input logic [9:0] ea,
                        input bit c, input logic [31:0] ed, input bit push);
        @(negedge clk);
        req = r; we = w;
        addr[0] = a0; addr[1] = a1;
        be[0] = b0; be[1] = b1;
        wdata[0] = d0; wdata[1] = d1;
        #1;
        chk("gnt_lat1", {30'd0, gnt1}, {30'd0, eg});
        chk("gnt_lat2", {30'd0, gnt2}, {30'd0, eg});
        chk("sram_req", {30'd0, s1_req, s2_req}, {30'd0, |r, |r});
        chk("sram_addr_lat1", {22'd0, s1_addr}, {22'd0, ea});
        chk("sram_addr_lat2", {22'd0, s2_addr}, {22'd0, ea});
        if (push) exp_q.push_back('{port: eg, issue: cyc, chk: c, data: ed});
    endtask

    task automatic idle();
        step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 10'd0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        // Requests held during reset must not be granted.
        req = 2'b11;
        addr[0] = 32'h10;
        addr[1] = 32'h20;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_gnt", {28'd0, gnt1, gnt2}, 32'd0);
        chk("reset_sram_req", {30'd0, s1_req, s2_req}, 32'd0);
        chk("reset_rvalid", {28'd0, rv1, rv2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 2'b00;

        // Contention from reset: grants alternate starting with port 0.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                step(2'b11, 2'b00, 32'h40, 32'h44, 4'hF, 4'hF, 0, 0, 2'b01, 10'd16, 1'b1, 0, 1'b1);
            else
                step(2'b11, 2'b00, 32'h40, 32'h44, 4'hF, 4'hF, 0, 0, 2'b10, 10'd17, 1'b1, 0, 1'b1);
        end

        // Write from port 1, read back from port 0.
        step(2'b10, 2'b10, 0, 32'h10, 0, 4'hF, 0, 32'hDEADBEEF, 2'b10, 10'd4, 1'b0, 0, 1'b1);
        step(2'b01, 2'b00, 32'h10, 0, 4'hF, 0, 0, 0, 2'b01, 10'd4, 1'b1, 32'hDEADBEEF, 1'b1);

        // Byte enables.
        step(2'b10, 2'b10, 0, 32'h20, 0, 4'hF, 0, 32'hFFFFFFFF, 2'b10, 10'd8, 1'b0, 0, 1'b1);
        step(2'b01, 2'b01, 32'h20, 0, 4'h1, 0, 32'h000000AA, 0, 2'b01, 10'd8, 1'b0, 0, 1'b1);
        step(2'b10, 2'b00, 0, 32'h20, 0, 4'hF, 0, 0, 2'b10, 10'd8, 1'b1, 32'hFFFFFFAA, 1'b1);

        // Back-to-back reads from ports 0, 1, 0.
        step(2'b01, 2'b00, 32'h10, 0, 4'hF, 0, 0, 0, 2'b01, 10'd4, 1'b1, 32'hDEADBEEF, 1'b1);
        step(2'b10, 2'b00, 0, 32'h20, 0, 4'hF, 0, 0, 2'b10, 10'd8, 1'b1, 32'hFFFFFFAA, 1'b1);
        step(2'b01, 2'b00, 32'h10, 0, 4'hF, 0, 0, 0, 2'b01, 10'd4, 1'b1, 32'hDEADBEEF, 1'b1);

        // Address wrap, ignored high bits and ignored byte offset.
        step(2'b10, 2'b10, 0, 32'h1000, 0, 4'hF, 0, 32'h12345678, 2'b10, 10'd0, 1'b0, 0, 1'b1);
        step(2'b01, 2'b00, 32'h0, 0, 4'hF, 0, 0, 0, 2'b01, 10'd0, 1'b1, 32'h12345678, 1'b1);
        step(2'b10, 2'b00, 0, 32'hFFFFF010, 0, 4'hF, 0, 0, 2'b10, 10'd4, 1'b1, 32'hDEADBEEF, 1'b1);
        step(2'b01, 2'b00, 32'h13, 0, 4'hF, 0, 0, 0, 2'b01, 10'd4, 1'b1, 32'hDEADBEEF, 1'b1);

        // Pointer holds across an idle cycle: it still points at port 1.
        idle();
        step(2'b11, 2'b00, 32'h20, 32'h10, 4'hF, 4'hF, 0, 0, 2'b10, 10'd4, 1'b1, 32'hDEADBEEF, 1'b1);
        idle();
        idle();
        idle();

        // Reset with a read in flight: its response must never appear.
        step(2'b10, 2'b00, 0, 32'h10, 0, 4'hF, 0, 0, 2'b10, 10'd4, 1'b0, 0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req = 2'b11;
        @(negedge clk);
        #1;
        chk("midreset_gnt", {28'd0, gnt1, gnt2}, 32'd0);
        chk("midreset_sram_req", {30'd0, s1_req, s2_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post_reset_rvalid", {28'd0, rv1, rv2}, 32'd0);
        end
        step(2'b11, 2'b00, 32'h10, 32'h20, 4'hF, 4'hF, 0, 0, 2'b01, 10'd4, 1'b1, 32'hDEADBEEF, 1'b1);
        idle();
        idle();
        idle();

        chk("drained_lat1", ix1, exp_q.size());
        chk("drained_lat2", ix2, exp_q.size());
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
